// File: rtl/rpm_moving_avg_if.sv
// Sample/result bundle between the tooth-period capture logic and the
// RPM moving-sum filter. The capture side is the master, the filter the slave.
interface rpm_moving_avg_if #(
    parameter int LENGTH_INPUT = 16,
    parameter int DEPTH_LOG2   = 5,
    parameter int LENGTH_SUM   = LENGTH_INPUT + DEPTH_LOG2,
    parameter int LENGTH_WIN   = 3
);
    logic                    en;
    logic                    clear;
    logic [LENGTH_WIN-1:0]   win_log2;
    logic [LENGTH_INPUT-1:0] input_sample;
    logic [LENGTH_SUM-1:0]   output_sum;
    logic [LENGTH_SUM-1:0]   output_avg;
    logic                    out_valid;
    logic                    full;

    modport master (
        output en, clear, win_log2, input_sample,
        input  output_sum, output_avg, out_valid, full
    );

    modport slave (
        input  en, clear, win_log2, input_sample,
        output output_sum, output_avg, out_valid, full
    );
endinterface

// File: rtl/rpm_moving_avg.sv
// Runtime-configurable moving sum / moving average of RPM period samples.
// A circular buffer holds the most recent samples and a single accumulator
// tracks the window sum: each accepted sample is added, and once the window
// is full the sample falling out of the window is subtracted.
module rpm_moving_avg #(
    parameter int LENGTH_INPUT = 16,
    parameter int DEPTH_LOG2   = 5,
    parameter int LENGTH_SUM   = LENGTH_INPUT + DEPTH_LOG2,
    parameter int LENGTH_WIN   = 3
) (
    input  logic              clk,
    input  logic              reset,
    rpm_moving_avg_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   FILL_ONE = 1;
    localparam logic [LENGTH_WIN-1:0] K_MAX    = LENGTH_WIN'(DEPTH_LOG2);

    logic [LENGTH_INPUT-1:0] mem [DEPTH];

    logic [LENGTH_SUM-1:0]   sum;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2:0]     fill;
    logic [LENGTH_WIN-1:0]   k_reg;
    logic                    k_loaded;
    logic                    full_q;
    logic                    valid_q;

    logic [LENGTH_WIN-1:0]   k_in;
    logic [DEPTH_LOG2:0]     w_full;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [LENGTH_INPUT-1:0] oldest;
    logic                    flush;
    logic                    accept;
    logic                    at_window;
    logic [DEPTH_LOG2:0]     fill_next;
    logic [LENGTH_SUM-1:0]   sum_next;

    // Window select clamping, oldest-sample lookup and next-sum arithmetic.
    // A window change (or the first clock after reset, which loads k_reg)
    // flushes exactly like clear, and any sample in that cycle is dropped.
    always_comb begin
        k_in      = (bus.win_log2 > K_MAX) ? K_MAX : bus.win_log2;
        w_full    = FILL_ONE << k_reg;
        // At the maximum window w_full truncates to zero, so the oldest slot
        // is the one about to be overwritten.
        rd_ptr    = wr_ptr - w_full[DEPTH_LOG2-1:0];
        oldest    = mem[rd_ptr];
        flush     = bus.clear || !k_loaded || (k_in != k_reg);
        accept    = bus.en && !flush;
        at_window = (fill == w_full);
        fill_next = at_window ? fill : fill + FILL_ONE;
        sum_next  = sum + LENGTH_SUM'(bus.input_sample)
                  - (at_window ? LENGTH_SUM'(oldest) : '0);
    end

    // Sample storage; contents are don't-care after reset or clear because
    // the fill gate keeps stale entries out of the sum.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus.input_sample;
        end
    end

    // Accumulator, pointers, fill tracking and the registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum      <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
            k_reg    <= '0;
            k_loaded <= 1'b0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (flush) begin
                sum      <= '0;
                fill     <= '0;
                full_q   <= 1'b0;
                k_reg    <= k_in;
                k_loaded <= 1'b1;
            end else if (bus.en) begin
                sum     <= sum_next;
                wr_ptr  <= wr_ptr + PTR_ONE;
                fill    <= fill_next;
                full_q  <= (fill_next == w_full);
                valid_q <= 1'b1;
            end
        end
    end

    assign bus.output_sum = sum;
    assign bus.output_avg = sum >> k_reg;
    assign bus.out_valid  = valid_q;
    assign bus.full       = full_q;
endmodule

// File: tb/tb_rpm_moving_avg.sv
// Bench for rpm_moving_avg: directed stimulus with literal expectations, plus
// a queue-based reference that recomputes the window sum every cycle.
module tb_rpm_moving_avg;
    logic clk;
    logic reset;

    rpm_moving_avg_if bus ();

    rpm_moving_avg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_hist [$];
    int          m_k      = 0;
    bit          m_kvalid = 0;
    bit          m_valid  = 0;

    function automatic longint m_sum();
        longint s = 0;
        int     w = 1 << m_k;
        int     n = m_hist.size();
        for (int i = 0; i < n && i < w; i++) s += m_hist[n - 1 - i];
        return s;
    endfunction

    function automatic bit m_full();
        return m_kvalid && (m_hist.size() >= (1 << m_k));
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_hist.delete();
                m_kvalid = 0;
                m_valid  = 0;
            end else if (clk) begin
                int kin;
                kin = (int'(bus.win_log2) > 5) ? 5 : int'(bus.win_log2);
                m_valid = 0;
                if (!m_kvalid || kin != m_k || bus.clear) begin
                    m_hist.delete();
                    m_k      = kin;
                    m_kvalid = 1;
                end else if (bus.en) begin
                    m_hist.push_back(bus.input_sample);
                    if (m_hist.size() > 32) void'(m_hist.pop_front());
                    m_valid = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset) begin
            n_checks++;
            if (longint'(bus.output_sum) != m_sum()) begin
                n_errors++;
                $display("FAIL model_sum: got %0d expected %0d at %0t", bus.output_sum, m_sum(), $time);
            end
            n_checks++;
            if (bus.full !== m_full()) begin
                n_errors++;
                $display("FAIL model_full: got %0b expected %0b at %0t", bus.full, m_full(), $time);
            end
            n_checks++;
            if (bus.out_valid !== m_valid) begin
                n_errors++;
                $display("FAIL model_valid: got %0b expected %0b at %0t", bus.out_valid, m_valid, $time);
            end
            if (m_full()) begin
                n_checks++;
                if (longint'(bus.output_avg) != (m_sum() >> m_k)) begin
                    n_errors++;
                    $display("FAIL model_avg: got %0d expected %0d at %0t", bus.output_avg, m_sum() >> m_k, $time);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic lit(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Presents one sample for one clock; returns on the following falling
    // edge, where the updated sum is visible.
    task automatic send(input logic [15:0] s);
        bus.en           = 1'b1;
        bus.input_sample = s;
        @(negedge clk);
        bus.en = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    int seq_const [6] = '{100, 200, 300, 400, 400, 400};
    int seq_ramp  [8] = '{1, 3, 6, 10, 14, 18, 22, 26};

    initial begin
        reset            = 1'b0;
        bus.en           = 1'b0;
        bus.clear        = 1'b0;
        bus.win_log2     = 3'd2;
        bus.input_sample = '0;
        repeat (3) @(negedge clk);
        lit("reset_sum", bus.output_sum, 0);
        lit("reset_full", bus.full, 0);
        reset = 1'b1;

        // Reset and idle
        repeat (10) @(negedge clk);
        lit("idle_sum", bus.output_sum, 0);
        lit("idle_avg", bus.output_avg, 0);
        lit("idle_full", bus.full, 0);

        // Constant fill, k=2
        for (int i = 0; i < 6; i++) begin
            send(16'd100);
            lit("const_sum", bus.output_sum, seq_const[i]);
            lit("const_valid", bus.out_valid, 1);
            lit("const_full", bus.full, (i >= 3) ? 1 : 0);
        end
        lit("const_avg", bus.output_avg, 100);
        @(negedge clk);
        lit("valid_drop", bus.out_valid, 0);

        // Sliding ramp, k=2
        pulse_clear();
        lit("clear_sum", bus.output_sum, 0);
        for (int i = 0; i < 8; i++) begin
            send(16'(i + 1));
            lit("ramp_sum", bus.output_sum, seq_ramp[i]);
        end
        lit("ramp_avg", bus.output_avg, 6);

        // Clear concurrent with en drops the sample
        pulse_clear();
        for (int i = 0; i < 3; i++) send(16'd5);
        lit("pre_clear_sum", bus.output_sum, 15);
        bus.en           = 1'b1;
        bus.clear        = 1'b1;
        bus.input_sample = 16'd9;
        @(negedge clk);
        bus.en    = 1'b0;
        bus.clear = 1'b0;
        lit("clr_en_sum", bus.output_sum, 0);
        lit("clr_en_full", bus.full, 0);
        lit("clr_en_valid", bus.out_valid, 0);
        send(16'd7);
        lit("after_clr_sum", bus.output_sum, 7);

        // Window change 2 -> 1 mid-stream with a concurrent sample
        for (int i = 0; i < 4; i++) send(16'd10);
        lit("pre_win_full", bus.full, 1);
        bus.win_log2     = 3'd1;
        bus.en           = 1'b1;
        bus.input_sample = 16'd50;
        @(negedge clk);
        bus.en = 1'b0;
        lit("win_chg_sum", bus.output_sum, 0);
        lit("win_chg_full", bus.full, 0);
        send(16'd3);
        lit("win1_sum_a", bus.output_sum, 3);
        lit("win1_full_a", bus.full, 0);
        send(16'd4);
        lit("win1_sum_b", bus.output_sum, 7);
        lit("win1_full_b", bus.full, 1);
        lit("win1_avg", bus.output_avg, 3);
        send(16'd8);
        lit("win1_slide", bus.output_sum, 12);

        // win_log2=7 clamps to k=5
        bus.win_log2 = 3'd7;
        @(negedge clk);
        for (int i = 0; i < 31; i++) send(16'd1);
        lit("win7_sum31", bus.output_sum, 31);
        lit("win7_full31", bus.full, 0);
        send(16'd1);
        lit("win7_sum32", bus.output_sum, 32);
        lit("win7_full32", bus.full, 1);
        lit("win7_avg", bus.output_avg, 1);

        // Max-window saturation; 5 equals the clamped value, so no flush
        bus.win_log2 = 3'd5;
        pulse_clear();
        for (int i = 0; i < 40; i++) begin
            send(16'hFFFF);
            if (i >= 31) lit("sat_sum", bus.output_sum, 64'h1FFFE0);
        end
        lit("sat_avg", bus.output_avg, 64'hFFFF);
        lit("sat_full", bus.full, 1);

        // Async reset mid-stream
        bus.win_log2     = 3'd2;
        @(negedge clk);
        send(16'd20);
        bus.en           = 1'b1;
        bus.input_sample = 16'd30;
        @(posedge clk);
        #2;
        lit("pre_rst_sum", bus.output_sum, 50);
        reset = 1'b0;
        #1;
        lit("async_sum", bus.output_sum, 0);
        lit("async_avg", bus.output_avg, 0);
        lit("async_full", bus.full, 0);
        lit("async_valid", bus.out_valid, 0);
        bus.en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send(16'd9);
        lit("post_rst_sum", bus.output_sum, 9);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rpm_moving_avg.md
Name: rpm_moving_avg

Overview:
- Runtime-configurable moving-sum / moving-average filter for RPM period samples.
- Generalised successor to the fixed-length RPM shift-register sum: circular buffer plus a single running accumulator replaces the per-stage sum chain.
- Adds a selectable power-of-two window, a fill-tracking `full` flag, an averaged output, a synchronous clear and a sample-valid strobe.
- Sits between the tooth-period capture logic and the RPM computation.

Parameters:
- LENGTH_INPUT, 16, sample width in bits.
- DEPTH_LOG2, 5, log2 of the maximum window (default maximum window 32 samples).
- LENGTH_SUM, LENGTH_INPUT+DEPTH_LOG2, accumulator and sum width; guaranteed not to overflow.
- LENGTH_WIN, 3, width of win_log2; must satisfy 2^LENGTH_WIN > DEPTH_LOG2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; input_sample is accepted on a rising clk edge with en=1.
- clear  input  1  synchronous flush of the window contents.
- win_log2  input  LENGTH_WIN  window size select; window W = 2^k.
- input_sample  input  LENGTH_INPUT  unsigned sample.
- output_sum  output  LENGTH_SUM  sum of the last min(fill,W) accepted samples.
- output_avg  output  LENGTH_SUM  output_sum >> k.
- out_valid  output  1  one-cycle pulse when output_sum and output_avg update after an accepted sample.
- full  output  1  asserted when fill = W.

Behaviour:
- **Effective window select.** k = min(win_log2, DEPTH_LOG2); any larger value clamps to DEPTH_LOG2. k_reg holds the registered copy.
- **Reset** (reset=0, asynchronous): output_sum=0, output_avg=0, out_valid=0, full=0, wr_ptr=0, fill=0, k_reg=clamped win_log2 sampled on the first clock after release. Buffer contents are don't-care.
- **Storage.**
  - Buffer: 2^DEPTH_LOG2 entries × LENGTH_INPUT bits, addressed by wr_ptr (DEPTH_LOG2 bits).
  - wr_ptr wraps from 2^DEPTH_LOG2-1 to 0.
- **Fill counter.** fill is DEPTH_LOG2+1 bits and saturates at W.
- **Accepted sample** (en=1, clear=0, no window change):
  - oldest = buf[(wr_ptr - W) mod 2^DEPTH_LOG2], read before this cycle's write. When W = max, this is the slot being overwritten.
  - sum_next = sum + input_sample - (fill==W ? oldest : 0).
  - buf[wr_ptr] <= input_sample; wr_ptr <= wr_ptr+1; fill <= min(fill+1, W).
- **Latency.** Sum is updated 1 cycle after the accepting edge, i.e. registered on that edge. out_valid=1 for exactly that following cycle.
- **Outputs.**
  - output_avg is combinational from the registered sum and k_reg: sum >> k_reg.
  - output_avg is only meaningful while full=1.
  - full = (fill == 2^k_reg), registered.
- **Idle** (en=0): sum, fill, wr_ptr and buffer hold; out_valid=0.
- **clear=1:** sum<=0, fill<=0, full<=0, out_valid<=0; wr_ptr holds. Buffer is not zeroed; the fill gate prevents stale data from being subtracted.
- **clear and en in the same cycle:** clear wins; the sample is discarded.
- **Window change** (clamped win_log2 ≠ k_reg on a clock edge):
  - Treated exactly as clear, then k_reg <= new value.
  - An en in that same cycle is discarded.
- **Arithmetic.** Unsigned throughout. LENGTH_SUM is wide enough that 2^DEPTH_LOG2 × (2^LENGTH_INPUT - 1) never wraps.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronous); no partial update completes.

Test Plan:
- **Reset and idle:** hold reset=0, then release with en=0 for 10 cycles -> output_sum=0, output_avg=0, full=0, out_valid never asserts.
- **Constant fill, k=2:** 6 accepted samples of 100 -> output_sum sequence 100, 200, 300, 400, 400, 400; full rises with the 4th update; output_avg=100 once full; out_valid pulses once per sample, 1 cycle after each en.
- **Sliding ramp, k=2:** samples 1..8 -> sums 1, 3, 6, 10, 14, 18, 22, 26.
- **Max-window saturation:** k=5, 40 samples of 0xFFFF -> output_sum = 0x1FFFE0 from the 32nd update on; no overflow; output_avg = 0xFFFF; wr_ptr wrap exercised.
- **Clear and window change:**
  - clear asserted together with en after 3 samples -> sum=0, full=0, the concurrent sample is dropped; the next sample of 7 gives sum=7.
  - Changing win_log2 from 2 to 1 mid-stream flushes identically, and full then asserts after 2 samples.
  - win_log2=7 behaves as k=5.
- **Async reset mid-stream:** pull reset low between clock edges while en=1 -> outputs go to 0 immediately, without waiting for a clock edge.
